// File: rtl/button_pkg.sv
// button_pkg: shared state encoding and channel indices for the button front end.
package button_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} btn_state_t;
  localparam int unsigned BTN_DROP  = 0;
  localparam int unsigned BTN_RIGHT = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned NUM_BTN   = 3;
endpackage

// File: rtl/button_debounce.sv
// button_debounce: one button channel: 2-flop sync, debounce FSM, optional auto-repeat.
// Auto-repeat exists only when BUTTON_AUTOREPEAT_EN is defined.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250_000,
`ifdef BUTTON_AUTOREPEAT_EN
  parameter int unsigned REPEAT_DELAY    = 12_500_000,
  parameter int unsigned REPEAT_PERIOD   = 5_000_000,
  parameter bit          REPEAT_EN       = 1'b0,
`endif
  parameter int unsigned CNT_W           = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press_evt,
  output logic level
);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_q;
  btn_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic s, deb_evt;
  assign s = sync_q[1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    deb_evt = 1'b0;
    case (state_q)
      IDLE:      begin
        state_d = s ? PRESS_CHK : IDLE;
        cnt_d   = '0;
      end
      PRESS_CHK: begin
        state_d = !s ? IDLE : (cnt_q == DB_LAST) ? HELD : PRESS_CHK;
        deb_evt = s && (cnt_q == DB_LAST);
      end
      HELD:      begin
        state_d = s ? HELD : REL_CHK;
        cnt_d   = '0;
      end
      REL_CHK:   state_d = s ? HELD : (cnt_q == DB_LAST) ? IDLE : REL_CHK;
      default:   state_d = IDLE;
    endcase
  end
  // level tracks the next state so the registered output lines up with the press event
  assign level = (state_d == HELD) || (state_d == REL_CHK);
`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  logic [CNT_W-1:0] rep_q, rep_d;
  logic first_q, first_d, rep_evt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q   <= '0;
      first_q <= 1'b1;
    end else begin
      rep_q   <= rep_d;
      first_q <= first_d;
    end
  end
  // counter advances only while stably HELD, so REL_CHK freezes it
  always_comb begin
    rep_evt = REPEAT_EN && state_q == HELD && s && rep_q == (first_q ? DLY_LAST : PER_LAST);
    rep_d   = deb_evt ? '0 : rep_q;
    first_d = deb_evt | first_q;
    if (REPEAT_EN && state_q == HELD && s) begin
      rep_d   = rep_evt ? '0 : (&rep_q) ? rep_q : rep_q + 1'b1;
      first_d = first_q & ~rep_evt;
    end
  end
  assign press_evt = deb_evt | rep_evt;
`else
  assign press_evt = deb_evt;
`endif
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced one-cycle press pulses for drop/right/left buttons.
// Define BUTTON_AUTOREPEAT_EN to enable auto-repeat on the right/left channels.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250_000,
`ifdef BUTTON_AUTOREPEAT_EN
  parameter int unsigned REPEAT_DELAY    = 12_500_000,
  parameter int unsigned REPEAT_PERIOD   = 5_000_000,
`endif
  parameter int unsigned CNT_W           = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_BTN-1:0] btn_level
);
  localparam logic [NUM_BTN-1:0] DIR_MASK = NUM_BTN'((1 << BTN_RIGHT) | (1 << BTN_LEFT));
  logic [NUM_BTN-1:0] evt, pulse_d, pulse_q, level_d, level_q;
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`ifdef BUTTON_AUTOREPEAT_EN
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .REPEAT_EN(i != BTN_DROP),
`endif
      .CNT_W(CNT_W)
    ) u_deb (
      .clk(clk),
      .rst_n(rst_n),
      .btn_raw(btn_raw[i]),
      .press_evt(evt[i]),
      .level(level_d[i])
    );
  end
  // simultaneous left+right events cancel each other; drop is unaffected
  always_comb pulse_d = (evt[BTN_RIGHT] && evt[BTN_LEFT]) ? evt & ~DIR_MASK : evt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= '0;
      level_q <= '0;
    end else begin
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end
  assign btn_pulse = pulse_q;
  assign btn_level = level_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and random stimulus against a sample-history reference model.
module tb_button_conditioner;
  import button_pkg::*;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] btn_raw = 3'b000;
  logic [2:0] btn_pulse, btn_level;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
`ifdef BUTTON_AUTOREPEAT_EN
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
`endif
    .CNT_W(24)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_pulse(btn_pulse),
    .btn_level(btn_level)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0b exp=%0b t=%0t", tag, got, exp, $time);
    end
  endtask
  // Reference: level flips once the last D+1 synchronised samples all disagree with it.
  logic [2:0] p1, p2, m_s, m_evt, exp_pulse, exp_level;
  logic [2:0] hist[$];
  int adv[3];
  bit m_flip;
  task automatic model_reset();
    p1 = 0; p2 = 0; hist.delete();
    exp_pulse = 0; exp_level = 0;
    adv = '{default: 0};
  endtask
  task automatic model_step();
    m_s = p2; p2 = p1; p1 = btn_raw;
    hist.push_front(m_s);
    if (hist.size() > D + 1) void'(hist.pop_back());
    m_evt = 0;
    for (int c = 0; c < 3; c++) begin
      m_flip = (hist.size() == D + 1);
      for (int j = 0; j < hist.size(); j++) if (hist[j][c] == exp_level[c]) m_flip = 0;
      if (m_flip) begin
        exp_level[c] = ~exp_level[c];
        m_evt[c] = exp_level[c];
        adv[c] = 0;
      end
`ifdef BUTTON_AUTOREPEAT_EN
      else if (c != BTN_DROP && exp_level[c] && hist[1][c] && m_s[c]) begin
        adv[c]++;
        if (adv[c] >= RD && (adv[c] - RD) % RP == 0) m_evt[c] = 1;
      end
`endif
    end
    exp_pulse = (m_evt[1] && m_evt[2]) ? (m_evt & 3'b001) : m_evt;
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end
  always @(negedge clk) begin
    check("pulse_model", btn_pulse, exp_pulse);
    check("level_model", btn_level, exp_level);
  end
  logic [2:0] seen;
  int n[3];
  task automatic step();
    @(posedge clk);
    #1;
    seen |= btn_pulse;
    for (int c = 0; c < 3; c++) n[c] += btn_pulse[c];
  endtask
  task automatic run(input int k);
    repeat (k) step();
  endtask
  task automatic clr();
    seen = 0;
    n = '{default: 0};
  endtask
  initial begin
    clr();
    run(3);
    check("rst_pulse", btn_pulse, 0);
    check("rst_level", btn_level, 0);
    rst_n = 1;
    btn_raw = 3'b001;
    run(6);
    check("press_early", btn_pulse, 0);
    step();
    check("press_pulse", btn_pulse, 3'b001);
    check("press_level", btn_level, 3'b001);
    step();
    check("press_once", btn_pulse, 0);
    btn_raw = 0; run(10);
    clr();
    btn_raw = 3'b010; step(); btn_raw = 0; step(); btn_raw = 3'b010; step(); btn_raw = 0;
    run(12);
    check("bounce_pulse", seen, 0);
    check("bounce_level", btn_level, 0);
    clr();
    btn_raw = 3'b110; run(12);
    check("conflict_pulse", seen, 0);
    check("conflict_level", btn_level, 3'b110);
    btn_raw = 0; run(10);
    clr();
    btn_raw = 3'b111; run(12);
    check("conflict_drop", seen, 3'b001);
    check("conflict_level3", btn_level, 3'b111);
    btn_raw = 0; run(10);
    clr();
    btn_raw = 3'b010; run(12);
    btn_raw = 0; run(2);
    btn_raw = 3'b010; run(12);
    check("relbounce_cnt", n[1], 1);
    btn_raw = 0; run(6);
    check("release_hold", btn_level[1], 1);
    step();
    check("release_level", btn_level[1], 0);
    run(4);
    btn_raw = 3'b001; run(10);
    rst_n = 0; #1;
    check("rst_held_pulse", btn_pulse, 0);
    check("rst_held_level", btn_level, 0);
    step();
    rst_n = 1; clr();
    run(6);
    check("rst_rel_early", btn_pulse, 0);
    step();
    check("rst_rel_pulse", btn_pulse, 3'b001);
    run(8);
    check("rst_rel_once", n[0], 1);
    btn_raw = 0; run(10);
    btn_raw = 3'b001; run(3);
    rst_n = 0; #1;
    check("rst_chk_level", btn_level, 0);
    step();
    rst_n = 1;
    run(7);
    check("rst_chk_pulse", btn_pulse, 3'b001);
    btn_raw = 0; run(10);
    clr();
    btn_raw = 3'b001; run(36);
    check("drop_once", n[0], 1);
    btn_raw = 0; run(10);
    clr();
    btn_raw = 3'b010;
`ifdef BUTTON_AUTOREPEAT_EN
    run(7);
    check("rep_press", btn_pulse, 3'b010);
    run(10);
    check("rep_first", btn_pulse, 3'b010);
    run(3);
    check("rep_period", btn_pulse, 3'b010);
    run(16);
`else
    run(36);
    check("right_once", n[1], 1);
`endif
    btn_raw = 0; run(10);
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, ((k / 500) % 2) ? 3 : 12) == 0) btn_raw[b] = ~btn_raw[b];
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 0; #1;
        step();
        rst_n = 1;
      end else step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
